usb_transmitter: RTL
====================

Name: usb_transmitter

Overview:
- Transmit-side counterpart of the full-speed USB receive path.
- Accepts one packet descriptor (PID, up to 8 data bytes, packet type) and serialises it LSB-first onto d_plus/d_minus.
- Transmission order: SYNC, PID, optional data, CRC16, then EOP. Applies bit stuffing and NRZI encoding.
- Drives the bus lines from the encryptor datapath back toward the host.

Parameters:
- CLKS_PER_BIT, 8, clk cycles per USB bit time; legal range 2..255.
- MAX_BYTES, 8, maximum data payload in bytes.

Ports:
- clk  input  1  system clock
- n_rst  input  1  asynchronous active-low reset
- tx_start  input  1  one-cycle request; sampled only in IDLE
- tx_pid  input  8  PID byte, sent as-is (check nibble supplied by caller)
- tx_data_pkt  input  1  1 = data packet (payload + CRC16); 0 = handshake (SYNC+PID+EOP only)
- tx_len  input  4  payload byte count, 0..8; values >8 clamp to 8
- tx_data  input  64  payload; byte 0 = tx_data[7:0], sent first
- d_plus  output  1  D+ line
- d_minus  output  1  D- line
- tx_busy  output  1  high from accept until end of EOP J bit
- tx_done  output  1  one-cycle pulse after packet completes

Behaviour:
- Single clock domain: clk. Reset asynchronous, active-low on n_rst.
- Reset values: d_plus=1, d_minus=0 (idle J), tx_busy=0, tx_done=0, FSM=IDLE, NRZI level=J, ones count=0, CRC=16'hFFFF.
- Accept: tx_start=1 in IDLE latches tx_pid, tx_data, clamped tx_len and tx_data_pkt. tx_busy rises next cycle; the first SYNC bit appears on the lines that same cycle.
- tx_start is ignored while tx_busy=1. Inputs need not be held after accept.
- Bit timer: counts 0..CLKS_PER_BIT-1. Each line state holds exactly CLKS_PER_BIT cycles; the next bit is decided when the timer wraps.
- FSM states: IDLE -> SYNC(8 bits, 8'h80 LSB-first = 0000_0001) -> PID(8) -> DATA(8*len, skipped if len=0 or !data_pkt) -> CRC(16, only if data_pkt) -> EOP_SE0(2 bit times) -> EOP_J(1 bit time) -> IDLE.
- tx_done pulses on the cycle the FSM re-enters IDLE; tx_busy falls in that same cycle.
- NRZI: logical 0 toggles the line between J(1,0) and K(0,1); logical 1 holds it. SE0 = (0,0). After EOP_J the NRZI level is J.
- Bit stuffing:
  - The ones counter spans SYNC through the last CRC bit.
  - After 6 consecutive logical 1s, the next bit slot carries a stuffed 0 (line toggles). The stuffed slot does not advance the field bit counter and does not feed the CRC.
  - If the 6th one is the final CRC bit (or final PID bit of a handshake), the stuffed 0 is sent before EOP_SE0.
  - Any logical 0, including a stuffed 0, resets the ones counter.
- CRC16:
  - Polynomial x^16+x^15+x^2+1 (0x8005, reflected LSB-first shift). Init 16'hFFFF, updated per payload data bit only (not SYNC/PID).
  - The complement is transmitted, LSB (x^15 coefficient term) first.
  - Zero-length data packet therefore sends sixteen 0 bits.
- Reset mid-packet: lines return to J asynchronously, all state is cleared, and no tx_done is issued.
- Field bit counter: 7 bits (covers 64 data bits); byte/bit index = counter[5:3]/counter[2:0].

Decomposition:
- Shared package usb_pkg: typedef enum tx_state_t {IDLE, SYNC, PID, DATA, CRC, EOP_SE0, EOP_J}; constants SYNC_BYTE=8'h80, CRC16_POLY=16'h8005, CRC16_INIT=16'hFFFF, CRC16_RESIDUAL=16'h800D, PID codes (ACK 8'hD2, NAK 8'h5A, DATA0 8'hC3, DATA1 8'h4B). The receiver shares the same package.
- One sub-module: usb_crc16_serial, with ports clk, n_rst, clear, enable, bit_in, crc_out[15:0]. It is reusable for the receiver check path.
- Bit timer, stuffing counter and NRZI stay in the top module.

Test Plan:
- ACK: tx_pid=8'hD2, tx_data_pkt=0, CLKS_PER_BIT=8 -> line bits K J K J K J K K | J J K J J K K K | SE0 SE0 J; tx_busy high 152 cycles; tx_done one pulse at cycle 153.
- DATA1 zero-length: tx_pid=8'h4B, tx_data_pkt=1, tx_len=0 -> SYNC, PID, 16 CRC bits all logical 0 (line toggles every bit), then EOP; 35 bit times total.
- Stuffing: DATA0 8'hC3, tx_len=1, tx_data[7:0]=8'hFF -> stuffed 0 inserted after the 4th data bit (PID ends in two 1s). Decoding data+CRC with the receiver leaves residual 16'h800D.
- Max payload: tx_len=4'hF, tx_data=64'h0706050403020100 -> exactly 8 bytes sent (clamped). Independent CRC model matches; receiver rcv_data equals the input.
- Busy reject: second tx_start 10 cycles after the first (ACK) -> ignored; exactly one packet and one tx_done.
- Reset mid-DATA: assert n_rst low 3 cycles during byte 2 -> lines (1,0) immediately, tx_busy=0, no tx_done. A fresh ACK then transmits correctly from J.

Source files
------------

// File: rtl/usb_pkg.sv
// Shared USB definitions for the full-speed transmit and receive paths:
// transmitter FSM states, framing constants, PID codes and the serial CRC16 step.
package usb_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SYNC    = 3'd1,
    PID     = 3'd2,
    DATA    = 3'd3,
    CRC     = 3'd4,
    EOP_SE0 = 3'd5,
    EOP_J   = 3'd6
  } tx_state_t;

  localparam logic [7:0]  SYNC_BYTE      = 8'h80;
  localparam logic [15:0] CRC16_POLY     = 16'h8005;
  // CRC16_POLY bit-reversed, used by the LSB-first (reflected) shift register.
  localparam logic [15:0] CRC16_POLY_REFL = 16'hA001;
  localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
  localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;

  localparam logic [7:0] PID_ACK   = 8'hD2;
  localparam logic [7:0] PID_NAK   = 8'h5A;
  localparam logic [7:0] PID_DATA0 = 8'hC3;
  localparam logic [7:0] PID_DATA1 = 8'h4B;

  // One serial CRC16 step in reflected form: bit 0 of the register holds the
  // x^15 coefficient, so the complement is sent starting from bit 0.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic bit_in);
    logic fb;
    fb = crc[0] ^ bit_in;
    crc16_step = {1'b0, crc[15:1]} ^ (fb ? CRC16_POLY_REFL : 16'h0000);
  endfunction

endpackage

// File: rtl/usb_crc16_serial.sv
// Serial USB CRC16 accumulator, one bit per enabled cycle. Shared by the
// transmitter (CRC generation) and the receiver (residual check).
module usb_crc16_serial
  import usb_pkg::*;
(
  input  logic        clk,
  input  logic        n_rst,
  input  logic        clear,
  input  logic        enable,
  input  logic        bit_in,
  output logic [15:0] crc_out
);

  logic [15:0] crc_r;

  // CRC register: clear has priority over a data bit update.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      crc_r <= CRC16_INIT;
    end else if (clear) begin
      crc_r <= CRC16_INIT;
    end else if (enable) begin
      crc_r <= crc16_step(crc_r, bit_in);
    end else begin
      crc_r <= crc_r;
    end
  end

  assign crc_out = crc_r;

endmodule

// File: rtl/usb_transmitter.sv
// Full-speed USB packet transmitter: serialises SYNC, PID, optional payload
// and CRC16 LSB-first with bit stuffing and NRZI, then drives EOP.
// Line outputs are registered; J = (1,0), K = (0,1), SE0 = (0,0).
module usb_transmitter
  import usb_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 8,
  parameter int unsigned MAX_BYTES    = 8
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        tx_start,
  input  logic [7:0]  tx_pid,
  input  logic        tx_data_pkt,
  input  logic [3:0]  tx_len,
  input  logic [63:0] tx_data,
  output logic        d_plus,
  output logic        d_minus,
  output logic        tx_busy,
  output logic        tx_done
);

  localparam logic [7:0] TIMER_LAST = 8'(CLKS_PER_BIT - 1);
  localparam logic [3:0] MAX_LEN    = 4'(MAX_BYTES);

  tx_state_t   state_r, state_next_s, adv_state_s;
  logic [6:0]  cnt_r, cnt_next_s, adv_cnt_s;
  logic [7:0]  timer_r, timer_next_s;
  logic [2:0]  ones_r, ones_next_s;
  logic        nrzi_r, nrzi_next_s;          // 1 = J level, 0 = K level
  logic [7:0]  pid_r, pid_next_s;
  logic [63:0] data_r, data_next_s;
  logic [3:0]  len_r, len_next_s;
  logic        pkt_r, pkt_next_s;
  logic        dp_r, dp_next_s, dm_r, dm_next_s;
  logic        busy_r, busy_next_s, done_r, done_next_s;

  logic        wrap_s, adv_bit_s, stuff_region_s, data_last_s;
  logic [6:0]  data_bits_s;
  logic        crc_clear_s, crc_en_s, crc_bit_s;
  logic [15:0] crc_s;

  usb_crc16_serial u_crc (
    .clk     (clk),
    .n_rst   (n_rst),
    .clear   (crc_clear_s),
    .enable  (crc_en_s),
    .bit_in  (crc_bit_s),
    .crc_out (crc_s)
  );

  assign wrap_s         = (timer_r == TIMER_LAST);
  assign data_bits_s    = {len_r, 3'b000};
  assign data_last_s    = (cnt_r == (data_bits_s - 7'd1));
  assign stuff_region_s = (state_r == SYNC) || (state_r == PID) ||
                          (state_r == DATA) || (state_r == CRC);

  // Field position that follows the bit currently on the line (ignores stuffing).
  always_comb begin
    adv_state_s = IDLE;
    adv_cnt_s   = 7'd0;
    case (state_r)
      SYNC: begin
        if (cnt_r == 7'd7) begin
          adv_state_s = PID;
        end else begin
          adv_state_s = SYNC;
          adv_cnt_s   = cnt_r + 7'd1;
        end
      end
      PID: begin
        if (cnt_r != 7'd7) begin
          adv_state_s = PID;
          adv_cnt_s   = cnt_r + 7'd1;
        end else if (!pkt_r) begin
          adv_state_s = EOP_SE0;
        end else if (len_r == 4'd0) begin
          adv_state_s = CRC;
        end else begin
          adv_state_s = DATA;
        end
      end
      DATA: begin
        if (data_last_s) begin
          adv_state_s = CRC;
        end else begin
          adv_state_s = DATA;
          adv_cnt_s   = cnt_r + 7'd1;
        end
      end
      CRC: begin
        if (cnt_r == 7'd15) begin
          adv_state_s = EOP_SE0;
        end else begin
          adv_state_s = CRC;
          adv_cnt_s   = cnt_r + 7'd1;
        end
      end
      EOP_SE0: begin
        if (cnt_r == 7'd1) begin
          adv_state_s = EOP_J;
        end else begin
          adv_state_s = EOP_SE0;
          adv_cnt_s   = cnt_r + 7'd1;
        end
      end
      EOP_J:   adv_state_s = IDLE;
      default: adv_state_s = IDLE;
    endcase
  end

  // Logical value of the bit at the advanced position; CRC is sent complemented.
  always_comb begin
    case (adv_state_s)
      SYNC:    adv_bit_s = SYNC_BYTE[adv_cnt_s[2:0]];
      PID:     adv_bit_s = pid_r[adv_cnt_s[2:0]];
      DATA:    adv_bit_s = data_r[adv_cnt_s[5:0]];
      CRC:     adv_bit_s = ~crc_s[adv_cnt_s[3:0]];
      default: adv_bit_s = 1'b0;
    endcase
  end

  // Next-state and line decisions: accept in IDLE, otherwise act on each bit-timer wrap.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    timer_next_s = timer_r;
    ones_next_s  = ones_r;
    nrzi_next_s  = nrzi_r;
    pid_next_s   = pid_r;
    data_next_s  = data_r;
    len_next_s   = len_r;
    pkt_next_s   = pkt_r;
    dp_next_s    = dp_r;
    dm_next_s    = dm_r;
    busy_next_s  = busy_r;
    done_next_s  = 1'b0;
    crc_clear_s  = 1'b0;
    crc_en_s     = 1'b0;
    crc_bit_s    = 1'b0;

    if (state_r == IDLE) begin
      if (tx_start) begin
        pid_next_s   = tx_pid;
        data_next_s  = tx_data;
        len_next_s   = (tx_len > MAX_LEN) ? MAX_LEN : tx_len;
        pkt_next_s   = tx_data_pkt;
        state_next_s = SYNC;
        cnt_next_s   = 7'd0;
        timer_next_s = 8'd0;
        nrzi_next_s  = SYNC_BYTE[0] ? nrzi_r : ~nrzi_r;
        ones_next_s  = SYNC_BYTE[0] ? 3'd1 : 3'd0;
        dp_next_s    = nrzi_next_s;
        dm_next_s    = ~nrzi_next_s;
        busy_next_s  = 1'b1;
        crc_clear_s  = 1'b1;
      end else begin
        dp_next_s   = 1'b1;
        dm_next_s   = 1'b0;
        busy_next_s = 1'b0;
      end
    end else if (!wrap_s) begin
      timer_next_s = timer_r + 8'd1;
    end else begin
      timer_next_s = 8'd0;
      if (stuff_region_s && (ones_r == 3'd6)) begin
        // Stuffed zero: position holds, CRC untouched, line toggles.
        ones_next_s = 3'd0;
        nrzi_next_s = ~nrzi_r;
        dp_next_s   = nrzi_next_s;
        dm_next_s   = ~nrzi_next_s;
      end else begin
        state_next_s = adv_state_s;
        cnt_next_s   = adv_cnt_s;
        case (adv_state_s)
          SYNC, PID, DATA, CRC: begin
            nrzi_next_s = adv_bit_s ? nrzi_r : ~nrzi_r;
            dp_next_s   = nrzi_next_s;
            dm_next_s   = ~nrzi_next_s;
            ones_next_s = adv_bit_s ? (ones_r + 3'd1) : 3'd0;
            crc_en_s    = (adv_state_s == DATA);
            crc_bit_s   = adv_bit_s;
          end
          EOP_SE0: begin
            ones_next_s = 3'd0;
            dp_next_s   = 1'b0;
            dm_next_s   = 1'b0;
          end
          EOP_J: begin
            nrzi_next_s = 1'b1;
            dp_next_s   = 1'b1;
            dm_next_s   = 1'b0;
          end
          IDLE: begin
            nrzi_next_s = 1'b1;
            dp_next_s   = 1'b1;
            dm_next_s   = 1'b0;
            busy_next_s = 1'b0;
            done_next_s = 1'b1;
          end
          default: begin
            state_next_s = IDLE;
            nrzi_next_s  = 1'b1;
            dp_next_s    = 1'b1;
            dm_next_s    = 1'b0;
            busy_next_s  = 1'b0;
          end
        endcase
      end
    end
  end

  // State and datapath registers; reset parks the lines at idle J.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_r <= IDLE;
      cnt_r   <= 7'd0;
      timer_r <= 8'd0;
      ones_r  <= 3'd0;
      nrzi_r  <= 1'b1;
      pid_r   <= 8'd0;
      data_r  <= 64'd0;
      len_r   <= 4'd0;
      pkt_r   <= 1'b0;
      dp_r    <= 1'b1;
      dm_r    <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
      timer_r <= timer_next_s;
      ones_r  <= ones_next_s;
      nrzi_r  <= nrzi_next_s;
      pid_r   <= pid_next_s;
      data_r  <= data_next_s;
      len_r   <= len_next_s;
      pkt_r   <= pkt_next_s;
      dp_r    <= dp_next_s;
      dm_r    <= dm_next_s;
      busy_r  <= busy_next_s;
      done_r  <= done_next_s;
    end
  end

  assign d_plus  = dp_r;
  assign d_minus = dm_r;
  assign tx_busy = busy_r;
  assign tx_done = done_r;

endmodule
